keypoint_tx_scheduler: RTL and testbench

- Shares one keypoint UART sender (BRAM-walking serializer, ports img_ready/busy/address/data) among N_SRC keypoint buffers, one per octave/scale.
- Arbitrates round-robin among buffers with a full keypoint set ready.
- Pulses the sender start, routes the sender's BRAM address to the granted buffer and its data back to the sender.
- Acknowledges the buffer when the dump completes; sits between the keypoint-detection BRAMs and the sender.

---
 rtl/keypoint_tx_scheduler_if.sv | 25 ++
 rtl/keypoint_tx_scheduler.sv | 168 ++++++++++++++++
 tb/tb_keypoint_tx_scheduler.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/keypoint_tx_scheduler_if.sv
// Sender-side bus of the keypoint TX scheduler: start pulse, busy,
// BRAM address from the serializer and keypoint data back to it.
interface keypoint_tx_scheduler_if #(
  parameter int BIT_DEPTH = 13,
  parameter int AW        = 10
);
  logic                 snd_start_out;
  logic                 snd_busy_in;
  logic [AW-1:0]        snd_addr_in;
  logic [BIT_DEPTH-1:0] snd_data_out;

  modport master (
    output snd_start_out,
    output snd_data_out,
    input  snd_busy_in,
    input  snd_addr_in
  );

  modport slave (
    input  snd_start_out,
    input  snd_data_out,
    output snd_busy_in,
    output snd_addr_in
  );
endinterface

// File: rtl/keypoint_tx_scheduler.sv
// Round-robin owner selection of one keypoint UART sender among
// N_SRC octave buffers; routes address/data and acks finished dumps.
module keypoint_tx_scheduler #(
  parameter int N_SRC         = 3,
  parameter int BIT_DEPTH     = 13,
  parameter int BRAM_LENGTH   = 1000,
  parameter int START_TIMEOUT = 64,
  parameter int GAP_CYCLES    = 16,
  localparam int AW           = $clog2(BRAM_LENGTH),
  localparam int SW           = $clog2(N_SRC)
) (
  input  logic                       clk,
  input  logic                       rst_in,
  input  logic [N_SRC-1:0]           req_in,
  input  logic [N_SRC*BIT_DEPTH-1:0] src_data_in,
  output logic [AW-1:0]              src_addr_out,
  output logic [N_SRC-1:0]           grant_out,
  output logic [N_SRC-1:0]           done_out,
  output logic [SW-1:0]              active_src_out,
  output logic                       idle_out,
  output logic                       error_out,
  keypoint_tx_scheduler_if.master    snd
);

  localparam int TW = $clog2(START_TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [TW-1:0] T_MAX = TW'(START_TIMEOUT - 1);
  localparam logic [GW-1:0] G_MAX = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_SENDING,
    S_DONE,
    S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [N_SRC-1:0] grant_q, grant_d;
  logic [N_SRC-1:0] done_q, done_d;
  logic             start_q, start_d;
  logic             err_q, err_d;
  logic [SW-1:0]    active_q, active_d;
  logic [SW-1:0]    last_q, last_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [SW:0]      pick;
  logic [BIT_DEPTH-1:0] data_mux;

  // First requester after the last served one, wrapping; MSB = found.
  function automatic logic [SW:0] rr_pick(
    input logic [N_SRC-1:0] req,
    input logic [SW-1:0]    last
  );
    logic [SW:0] r;
    int j;
    r = '0;
    for (int i = N_SRC; i >= 1; i--) begin
      j = (int'(last) + i) % N_SRC;
      if (req[j]) r = {1'b1, SW'(j)};
    end
    return r;
  endfunction

  assign pick = rr_pick(req_in, last_q);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    done_d   = '0;
    start_d  = 1'b0;
    err_d    = err_q;
    active_d = active_q;
    last_d   = last_q;
    timer_d  = timer_q;
    gap_d    = gap_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick[SW]) begin
          grant_d  = N_SRC'(1) << pick[SW-1:0];
          active_d = pick[SW-1:0];
          start_d  = 1'b1;
          state_d  = S_START;
        end
      end
      S_START: begin
        timer_d = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (snd.snd_busy_in) begin
          state_d = S_SENDING;
        end else if (timer_q == T_MAX) begin
          // Request stays pending; it is retried after the gap.
          err_d   = 1'b1;
          grant_d = '0;
          last_d  = active_q;
          gap_d   = '0;
          state_d = S_GAP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_SENDING: begin
        if (!snd.snd_busy_in) begin
          done_d  = grant_q;
          grant_d = '0;
          last_d  = active_q;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        gap_d   = '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_q == G_MAX) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      done_q   <= '0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
      active_q <= '0;
      last_q   <= SW'(N_SRC - 1);
      timer_q  <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      start_q  <= start_d;
      err_q    <= err_d;
      active_q <= active_d;
      last_q   <= last_d;
      timer_q  <= timer_d;
      gap_q    <= gap_d;
    end
  end

  always_comb begin
    data_mux = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant_q[i]) data_mux = src_data_in[i*BIT_DEPTH +: BIT_DEPTH];
    end
  end

  assign src_addr_out      = snd.snd_addr_in;
  assign snd.snd_data_out  = data_mux;
  assign snd.snd_start_out = start_q;
  assign grant_out         = grant_q;
  assign done_out          = done_q;
  assign active_src_out    = active_q;
  assign idle_out          = (state_q == S_IDLE);
  assign error_out         = err_q;

endmodule

// File: tb/tb_keypoint_tx_scheduler.sv
// Directed + randomized bench for keypoint_tx_scheduler with a
// transaction-level round-robin / timeline reference model.
module tb_keypoint_tx_scheduler;
  localparam int N   = 3;
  localparam int BD  = 13;
  localparam int AW  = 10;
  localparam int SW  = 2;
  localparam int TO  = 64;
  localparam int GAP = 16;

  logic            clk = 1'b0;
  logic            rst_in;
  logic [N-1:0]    req_in;
  logic [N*BD-1:0] src_data_in;
  logic [AW-1:0]   src_addr_out;
  logic [N-1:0]    grant_out;
  logic [N-1:0]    done_out;
  logic [SW-1:0]   active_src_out;
  logic            idle_out;
  logic            error_out;

  keypoint_tx_scheduler_if #(.BIT_DEPTH(BD), .AW(AW)) snd_if ();

  keypoint_tx_scheduler dut (
    .clk            (clk),
    .rst_in         (rst_in),
    .req_in         (req_in),
    .src_data_in    (src_data_in),
    .src_addr_out   (src_addr_out),
    .grant_out      (grant_out),
    .done_out       (done_out),
    .active_src_out (active_src_out),
    .idle_out       (idle_out),
    .error_out      (error_out),
    .snd            (snd_if)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [N-1:0]  exp_grant, exp_done;
  logic          exp_start, exp_error, exp_idle;
  logic [SW-1:0] exp_active;
  logic [SW-1:0] last_m;
  bit            fixed_data;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] req,
                                 input logic [SW-1:0] last);
    for (int i = 1; i <= N; i++) begin
      if (req[(int'(last) + i) % N]) return (int'(last) + i) % N;
    end
    return -1;
  endfunction

  task automatic drive_data();
    if (fixed_data) begin
      src_data_in = {13'h1ABC, 13'h0555, 13'h0555};
      snd_if.snd_addr_in = AW'(12);
    end else begin
      for (int i = 0; i < N; i++) src_data_in[i*BD +: BD] = BD'($urandom);
      snd_if.snd_addr_in = AW'($urandom_range(0, 999));
    end
  endtask

  task automatic check_outputs();
    chk("grant", 32'(grant_out), 32'(exp_grant));
    chk("done", 32'(done_out), 32'(exp_done));
    chk("start", 32'(snd_if.snd_start_out), 32'(exp_start));
    chk("error", 32'(error_out), 32'(exp_error));
    chk("active", 32'(active_src_out), 32'(exp_active));
    chk("idle", 32'(idle_out), 32'(exp_idle));
  endtask

  task automatic check_mux();
    logic [BD-1:0] ed;
    ed = (exp_grant != 0) ? src_data_in[int'(exp_active)*BD +: BD] : '0;
    chk("addr", 32'(src_addr_out), 32'(snd_if.snd_addr_in));
    chk("data", 32'(snd_if.snd_data_out), 32'(ed));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_outputs();
    drive_data();
    #1;
    check_mux();
  endtask

  task automatic idle_cycles(input int n);
    req_in    = '0;
    exp_grant = '0;
    exp_done  = '0;
    exp_start = 1'b0;
    exp_idle  = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  // One transfer seen from the edge that samples req_in in IDLE (r=0).
  // Sender raises busy after edge d and drops it after edge d+len.
  task automatic run_xfer(input int d, input int len, input bit to,
                          input logic [N-1:0] late);
    int owner, dn, tt, endr;
    logic [N-1:0] oh;
    owner = rr_pick(req_in, last_m);
    if (owner < 0) begin
      chk("no_request", 32'(req_in), 32'(1));
      return;
    end
    oh   = N'(1) << owner;
    dn   = d + len + 1;
    tt   = TO + 1;
    endr = to ? tt + GAP : dn + GAP + 1;
    exp_active = SW'(owner);
    for (int r = 0; r <= endr; r++) begin
      exp_start = (r == 0);
      exp_grant = (r < (to ? tt : dn)) ? oh : '0;
      exp_done  = (!to && r == dn) ? oh : '0;
      if (to && r >= tt) exp_error = 1'b1;
      exp_idle  = (r == endr);
      tick();
      if (r == 1) req_in = req_in | late;
      if (!to && r == dn) req_in = req_in & ~oh;
      snd_if.snd_busy_in = !to && r >= d && r < d + len;
    end
    last_m = SW'(owner);
  endtask

  initial begin
    rst_in = 1'b1;
    req_in = '0;
    fixed_data = 1'b0;
    snd_if.snd_busy_in = 1'b0;
    drive_data();
    exp_grant = '0; exp_done = '0; exp_start = 1'b0;
    exp_error = 1'b0; exp_idle = 1'b1; exp_active = '0;
    last_m = SW'(N - 1);
    #2;
    check_outputs();
    @(negedge clk);
    rst_in = 1'b0;
    idle_cycles(3);

    // single source, busy 2 cycles after start for 20 cycles
    req_in = 3'b010;
    run_xfer(2, 20, 1'b0, '0);

    // sender never answers: timeout, then retry of the same request
    req_in = 3'b001;
    run_xfer(0, 0, 1'b1, '0);
    run_xfer(3, 5, 1'b0, '0);
    idle_cycles(2);

    // async reset while SENDING
    req_in = 3'b010;
    exp_active = 2'd1; exp_grant = 3'b010; exp_start = 1'b1;
    exp_idle = 1'b0; exp_done = '0;
    tick();
    exp_start = 1'b0;
    tick();
    snd_if.snd_busy_in = 1'b1;
    tick();
    tick();
    #3;
    rst_in = 1'b1;
    #1;
    chk("rst_grant", 32'(grant_out), 32'(0));
    chk("rst_done", 32'(done_out), 32'(0));
    chk("rst_start", 32'(snd_if.snd_start_out), 32'(0));
    chk("rst_error", 32'(error_out), 32'(0));
    chk("rst_active", 32'(active_src_out), 32'(0));
    chk("rst_idle", 32'(idle_out), 32'(1));
    chk("rst_data", 32'(snd_if.snd_data_out), 32'(0));
    snd_if.snd_busy_in = 1'b0;
    exp_grant = '0; exp_done = '0; exp_start = 1'b0;
    exp_error = 1'b0; exp_idle = 1'b1; exp_active = '0;
    last_m = SW'(N - 1);
    #1;
    rst_in = 1'b0;
    req_in = 3'b101;
    run_xfer(1, 4, 1'b0, '0);
    run_xfer(2, 3, 1'b0, '0);

    // all sources requesting: round robin 0,1,2
    req_in = 3'b111;
    for (int i = 0; i < N; i++) begin
      run_xfer($urandom_range(1, 6), $urandom_range(1, 10), 1'b0, '0);
    end

    // data mux with fixed words and address
    fixed_data = 1'b1;
    idle_cycles(1);
    req_in = 3'b100;
    run_xfer(2, 6, 1'b0, '0);
    fixed_data = 1'b0;

    // late request raised during source 0 transfer
    req_in = 3'b001;
    run_xfer(2, 8, 1'b0, 3'b010);
    run_xfer(1, 3, 1'b0, '0);

    // randomized transfers
    for (int k = 0; k < 12; k++) begin
      req_in = req_in | N'($urandom_range(1, 7));
      run_xfer($urandom_range(1, 8), $urandom_range(1, 12),
               $urandom_range(0, 7) == 0, N'($urandom_range(0, 7)));
    end

    idle_cycles(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
